// File: rtl/eth_mac_pkg.sv
// rtl/eth_mac_pkg.sv - shared types and constants for the Ethernet MAC receive path
package eth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wr_state_t;

    localparam int ETH_MIN_FRAME_BYTES = 64;
    localparam int ETH_MAX_FRAME_BYTES = 1518;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_beat_t;

endpackage

// File: rtl/eth_sdp_ram.sv
// rtl/eth_sdp_ram.sv - simple dual-port RAM, one write port and one synchronous read port
module eth_sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ethernet_rx_frame_fifo.sv
// rtl/ethernet_rx_frame_fifo.sv - store-and-forward receive frame FIFO with bad/overflow frame rollback
// Optional frame statistics counters: define ETH_RX_FIFO_STATS_EN.
module ethernet_rx_frame_fifo
    import eth_mac_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tuser,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_drop,
    output logic        frame_overflow
`ifdef ETH_RX_FIFO_STATS_EN
    ,
    output logic [31:0] good_frame_count,
    output logic [31:0] drop_count,
    output logic [31:0] overflow_count
`endif
);

    localparam int               PTR_W     = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] FULL_USED = PTR_W'(DEPTH);

    wr_state_t        wr_state;
    logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic             full, accept, commit_evt, drop_evt, ovf_evt;
    byte_beat_t       wr_beat, rd_beat, skid_beat;
    logic             pend, skid_v, pop, fetch;
    logic [1:0]       occ;

    // rd_ptr only moves on an output handshake, so prefetched bytes still count as occupied.
    assign full       = (wr_ptr - rd_ptr) == FULL_USED;
    assign accept     = s_tvalid && (wr_state != DISCARD) && !full;
    assign commit_evt = accept && s_tlast && !s_tuser;
    assign drop_evt   = accept && s_tlast && s_tuser;
    assign ovf_evt    = s_tvalid && (wr_state != DISCARD) && full;
    assign wr_beat    = '{last: s_tlast, data: s_tdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state       <= IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            frame_drop     <= 1'b0;
            frame_overflow <= 1'b0;
        end else begin
            frame_drop     <= drop_evt;
            frame_overflow <= ovf_evt;
            if (s_tvalid) begin
                case (wr_state)
                    IDLE, WRITE: begin
                        if (ovf_evt) begin
                            wr_ptr   <= commit_ptr;
                            wr_state <= s_tlast ? IDLE : DISCARD;
                        end else if (drop_evt) begin
                            wr_ptr   <= commit_ptr;
                            wr_state <= IDLE;
                        end else if (commit_evt) begin
                            wr_ptr     <= wr_ptr + PTR_ONE;
                            commit_ptr <= wr_ptr + PTR_ONE;
                            wr_state   <= IDLE;
                        end else begin
                            wr_ptr   <= wr_ptr + PTR_ONE;
                            wr_state <= WRITE;
                        end
                    end
                    DISCARD: begin
                        if (s_tlast) begin
                            wr_state <= IDLE;
                        end
                    end
                    default: wr_state <= IDLE;
                endcase
            end
        end
    end

    eth_sdp_ram #(
        .WIDTH ($bits(byte_beat_t)),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (accept),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(wr_beat),
        .re   (fetch),
        .raddr(fetch_ptr[ADDR_W-1:0]),
        .rdata(rd_beat)
    );

    // Bytes in flight (RAM read pending) plus held in output and skid may never exceed two.
    assign pop   = m_tvalid && m_tready;
    assign occ   = {1'b0, pend} + {1'b0, m_tvalid} + {1'b0, skid_v};
    assign fetch = (fetch_ptr != commit_ptr) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            pend      <= 1'b0;
            skid_v    <= 1'b0;
            skid_beat <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
        end else begin
            pend <= fetch;
            if (fetch) begin
                fetch_ptr <= fetch_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pop || !m_tvalid) begin
                if (skid_v) begin
                    m_tdata  <= skid_beat.data;
                    m_tlast  <= skid_beat.last;
                    m_tvalid <= 1'b1;
                    skid_v   <= pend;
                    if (pend) begin
                        skid_beat <= rd_beat;
                    end
                end else if (pend) begin
                    m_tdata  <= rd_beat.data;
                    m_tlast  <= rd_beat.last;
                    m_tvalid <= 1'b1;
                end else begin
                    m_tvalid <= 1'b0;
                end
            end else if (pend) begin
                skid_beat <= rd_beat;
                skid_v    <= 1'b1;
            end
        end
    end

`ifdef ETH_RX_FIFO_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_frame_count <= '0;
            drop_count       <= '0;
            overflow_count   <= '0;
        end else begin
            if (commit_evt && (good_frame_count != 32'hFFFF_FFFF)) begin
                good_frame_count <= good_frame_count + 32'd1;
            end
            if (drop_evt && (drop_count != 32'hFFFF_FFFF)) begin
                drop_count <= drop_count + 32'd1;
            end
            if (ovf_evt && (overflow_count != 32'hFFFF_FFFF)) begin
                overflow_count <= overflow_count + 32'd1;
            end
        end
    end
`endif

endmodule
